// File: rtl/lsq_mem_arbiter.sv
// lsq_mem_arbiter: round-robin arbiter that shares one data-memory port among
// NUM_REQ load/store queues. One access is outstanding at a time. A load waits
// MEM_LAT cycles for read data. Each access ends with a one-cycle done pulse to
// the requester that won.
//
// Handshake: a request transfers on a rising edge where req_valid[i] and
// req_ready[i] are both high. req_ready is one-hot, and it is asserted only in
// IDLE while reset is low. The address, data and store bit are sampled only on
// that edge. A requester may lower req_valid at any time before its grant with
// no side effects.
module lsq_mem_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 16,
    parameter int MEM_LAT = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_is_store,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      mem_read_en,
    output logic                      mem_write_en,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_wdata,
    input  logic [DATA_W-1:0]         mem_rdata,
    output logic [NUM_REQ-1:0]        done,
    output logic [DATA_W-1:0]         resp_rdata,
    output logic                      busy,
    output logic [1:0]                dbg_state
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(MEM_LAT + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  wdata_q;
    logic               store_q;
    logic [PTR_W-1:0]   id_q;
    logic [DATA_W-1:0]  rdata_q;

    logic               any_valid;
    logic [PTR_W-1:0]   winner;

    // Round-robin pick: the first valid requester at or above ptr, modulo NUM_REQ.
    // The loop scans from the farthest offset down, so the nearest valid one is kept.
    always_comb begin
        int idx;
        any_valid = 1'b0;
        winner    = '0;
        idx       = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = int'(ptr_q) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (req_valid[PTR_W'(idx)]) begin
                any_valid = 1'b1;
                winner    = PTR_W'(idx);
            end
        end
    end

    // State register plus the grant-edge payload latch, latency counter and read capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            store_q <= 1'b0;
            id_q    <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: begin
                    if (any_valid) begin
                        addr_q  <= req_addr[int'(winner)*ADDR_W +: ADDR_W];
                        store_q <= req_is_store[winner];
                        id_q    <= winner;
                        ptr_q   <= (winner == PTR_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
                        // Write data is updated only for stores, so mem_wdata keeps its last value across loads.
                        if (req_is_store[winner]) begin
                            wdata_q <= req_wdata[int'(winner)*DATA_W +: DATA_W];
                        end
                    end
                end
                S_ISSUE: begin
                    if (!store_q) cnt_q <= CNT_W'(MEM_LAT);
                end
                S_WAIT: begin
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) rdata_q <= mem_rdata;
                end
                default: ;
            endcase
        end
    end

    // Next-state logic: ISSUE is one cycle, WAIT lasts MEM_LAT cycles, RESP is one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (any_valid) state_d = S_ISSUE;
            S_ISSUE: state_d = store_q ? S_RESP : S_WAIT;
            S_WAIT:  if (cnt_q == CNT_W'(1)) state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Strobes: grant, enables and done are all gated by reset, so an abandoned access has no effect.
    always_comb begin
        req_ready    = '0;
        mem_read_en  = 1'b0;
        mem_write_en = 1'b0;
        done         = '0;
        resp_rdata   = '0;
        if (!reset) begin
            case (state_q)
                S_IDLE:  if (any_valid) req_ready[winner] = 1'b1;
                S_ISSUE: begin
                    mem_write_en = store_q;
                    mem_read_en  = !store_q;
                end
                S_RESP: begin
                    done[id_q] = 1'b1;
                    resp_rdata = store_q ? '0 : rdata_q;
                end
                default: ;
            endcase
        end
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign busy      = (state_q != S_IDLE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_lsq_mem_arbiter.sv
// Testbench for lsq_mem_arbiter. The bench contains directed scenario tasks, a
// randomized run checked against a timeline model of grant, issue and done
// cycles, and a behavioural memory that returns data MEM_LAT cycles after a read.
module tb_lsq_mem_arbiter;

    localparam int N  = 4;
    localparam int AW = 8;
    localparam int DW = 16;
    localparam int L  = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req_valid, req_is_store;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N-1:0]    req_ready, done;
    logic            mem_read_en, mem_write_en, busy;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata, mem_rdata, resp_rdata;
    logic [1:0]      dbg_state;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [DW-1:0] mem_img [256];
    logic          rd_v [8];
    logic [AW-1:0] rd_a [8];
    logic [DW-1:0] exp_q [$];

    lsq_mem_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(L)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_is_store(req_is_store),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
        .mem_read_en(mem_read_en), .mem_write_en(mem_write_en), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .done(done),
        .resp_rdata(resp_rdata), .busy(busy), .dbg_state(dbg_state)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: read data appears exactly L cycles after the read-enable cycle; other cycles carry garbage
    always @(negedge clk) begin
        #2;
        rd_v[cyc % 8] = mem_read_en;
        rd_a[cyc % 8] = mem_addr;
        if (rd_v[(cyc + 8 - L) % 8]) mem_rdata = mem_img[rd_a[(cyc + 8 - L) % 8]];
        else mem_rdata = DW'($urandom);
    end

    task automatic set_req(input int i, input bit st, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[i]            = 1'b1;
        req_is_store[i]         = st;
        req_addr[i*AW +: AW]    = a;
        req_wdata[i*DW +: DW]   = d;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        req_valid = '0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1; req_valid = '1; req_is_store = '0; #1;
        n_tests++;
        if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready_a got %b want 0000", req_ready); end
        @(negedge clk); #1;
        n_tests++;
        if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready_b got %b want 0000", req_ready); end
        @(negedge clk);
        reset = 1'b0; req_valid = '0; #1;
        n_tests++;
        if ({req_ready, mem_read_en, mem_write_en, mem_addr, mem_wdata, done, resp_rdata, busy} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs got rdy=%b re=%b we=%b a=%h wd=%h done=%b rd=%h busy=%b want all 0",
                     req_ready, mem_read_en, mem_write_en, mem_addr, mem_wdata, done, resp_rdata, busy);
        end
    endtask

    task automatic test_single_load();
        @(negedge clk); set_req(2, 1'b0, 8'h3C, 16'h0); #1;
        n_tests++;
        if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL ld_grant got %b want 0100", req_ready); end
        @(negedge clk); req_valid = '0; #1;
        n_tests++;
        if (mem_read_en !== 1'b1 || mem_write_en !== 1'b0) begin
            n_fail++; $display("FAIL ld_enables got re=%b we=%b want re=1 we=0", mem_read_en, mem_write_en);
        end
        n_tests++;
        if (mem_addr !== 8'h3C) begin n_fail++; $display("FAIL ld_addr got %h want 3c", mem_addr); end
        repeat (3) @(negedge clk);
        #1;
        n_tests++;
        if (done !== 4'b0100) begin n_fail++; $display("FAIL ld_done got %b want 0100", done); end
        n_tests++;
        if (resp_rdata !== 16'hBEEF) begin n_fail++; $display("FAIL ld_data got %h want beef", resp_rdata); end
        @(negedge clk); #1;
        n_tests++;
        if (busy !== 1'b0 || done !== 4'b0000) begin
            n_fail++; $display("FAIL ld_after got busy=%b done=%b want 0 0000", busy, done);
        end
    endtask

    task automatic test_single_store();
        @(negedge clk); set_req(1, 1'b1, 8'h10, 16'h1234); #1;
        n_tests++;
        if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL st_grant got %b want 0010", req_ready); end
        @(negedge clk); req_valid = '0; #1;
        n_tests++;
        if (mem_write_en !== 1'b1 || mem_read_en !== 1'b0) begin
            n_fail++; $display("FAIL st_enables got we=%b re=%b want we=1 re=0", mem_write_en, mem_read_en);
        end
        n_tests++;
        if (mem_addr !== 8'h10 || mem_wdata !== 16'h1234) begin
            n_fail++; $display("FAIL st_payload got a=%h wd=%h want 10 1234", mem_addr, mem_wdata);
        end
        @(negedge clk); #1;
        n_tests++;
        if (done !== 4'b0010 || resp_rdata !== 16'h0 || mem_read_en !== 1'b0) begin
            n_fail++; $display("FAIL st_done got done=%b rd=%h re=%b want 0010 0000 0", done, resp_rdata, mem_read_en);
        end
        @(negedge clk); #1;
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL st_after got busy=%b want 0", busy); end
    endtask

    task automatic test_round_robin();
        int got;
        int last_c;
        got = 0;
        last_c = 0;
        do_reset();
        @(negedge clk);
        for (int i = 0; i < N; i++) set_req(i, 1'b0, AW'($urandom), 16'h0);
        for (int c = 0; c < 100 && got < 6; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            if (req_ready !== 4'b0000) begin
                n_tests++;
                if (req_ready !== 4'(1 << (got % N))) begin
                    n_fail++; $display("FAIL rr_order grant#%0d got %b want %b", got, req_ready, 4'(1 << (got % N)));
                end
                if (got > 0) begin
                    n_tests++;
                    if (cyc - last_c != L + 3) begin
                        n_fail++; $display("FAIL rr_spacing grant#%0d got %0d cycles want %0d", got, cyc - last_c, L + 3);
                    end
                end
                last_c = cyc;
                got++;
            end
        end
        n_tests++;
        if (got != 6) begin n_fail++; $display("FAIL rr_count got %0d grants want 6", got); end
        @(negedge clk); req_valid = '0;
        repeat (L + 3) @(negedge clk);
    endtask

    task automatic test_wrap();
        @(negedge clk); set_req(3, 1'b1, 8'h33, 16'h3333); #1;
        n_tests++;
        if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL wrap_grant3 got %b want 1000", req_ready); end
        @(negedge clk); req_valid = '0;
        @(negedge clk);
        @(negedge clk); set_req(0, 1'b1, 8'h40, 16'h4040); set_req(3, 1'b1, 8'h43, 16'h4343); #1;
        n_tests++;
        if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL wrap_first0 got %b want 0001", req_ready); end
        @(negedge clk); req_valid[0] = 1'b0;
        @(negedge clk);
        @(negedge clk); #1;
        n_tests++;
        if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL wrap_then3 got %b want 1000", req_ready); end
        @(negedge clk); req_valid = '0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_withdraw();
        @(negedge clk); set_req(2, 1'b0, 8'h3C, 16'h0); #1;
        n_tests++;
        if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL wd_grant got %b want 0100", req_ready); end
        @(negedge clk); req_valid = '0;
        @(negedge clk); set_req(1, 1'b0, 8'h55, 16'h0); #1;
        n_tests++;
        if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL wd_held_a got %b want 0000", req_ready); end
        @(negedge clk); req_valid[1] = 1'b0; #1;
        n_tests++;
        if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL wd_held_b got %b want 0000", req_ready); end
        @(negedge clk); #1;
        n_tests++;
        if (done !== 4'b0100) begin n_fail++; $display("FAIL wd_done got %b want 0100", done); end
        @(negedge clk);
        set_req(0, 1'b1, 8'h60, 16'h6060); set_req(1, 1'b1, 8'h61, 16'h6161); set_req(3, 1'b1, 8'h63, 16'h6363); #1;
        n_tests++;
        if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL wd_ptr got %b want 1000", req_ready); end
        @(negedge clk); req_valid = '0;
        @(negedge clk); #1;
        n_tests++;
        if (done !== 4'b1000) begin n_fail++; $display("FAIL wd_done2 got %b want 1000", done); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int seen;
        seen = 0;
        @(negedge clk); set_req(0, 1'b0, 8'h3C, 16'h0); #1;
        n_tests++;
        if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL rm_grant got %b want 0001", req_ready); end
        @(negedge clk); req_valid = '0;
        @(negedge clk);
        @(negedge clk); reset = 1'b1; #1;
        n_tests++;
        if (req_ready !== 4'b0000 || done !== 4'b0000) begin
            n_fail++; $display("FAIL rm_in_reset got rdy=%b done=%b want 0000 0000", req_ready, done);
        end
        @(negedge clk); reset = 1'b0; #1;
        n_tests++;
        if ({req_ready, mem_read_en, mem_write_en, mem_addr, mem_wdata, done, resp_rdata, busy} !== '0) begin
            n_fail++;
            $display("FAIL rm_outputs got rdy=%b re=%b we=%b a=%h wd=%h done=%b rd=%h busy=%b want all 0",
                     req_ready, mem_read_en, mem_write_en, mem_addr, mem_wdata, done, resp_rdata, busy);
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); #1;
            if (done !== 4'b0000) seen++;
        end
        n_tests++;
        if (seen != 0) begin n_fail++; $display("FAIL rm_no_done got %0d done cycles want 0", seen); end
        @(negedge clk); set_req(0, 1'b1, 8'hA5, 16'h5A5A); #1;
        n_tests++;
        if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL rm_regrant got %b want 0001", req_ready); end
        @(negedge clk); req_valid = '0; reset = 1'b1; #1;
        n_tests++;
        if (mem_write_en !== 1'b0) begin n_fail++; $display("FAIL rm_we_suppressed got %b want 0", mem_write_en); end
        @(negedge clk); reset = 1'b0; #1;
        n_tests++;
        if (busy !== 1'b0 || done !== 4'b0000) begin
            n_fail++; $display("FAIL rm_after_st got busy=%b done=%b want 0 0000", busy, done);
        end
    endtask

    task automatic test_random();
        int m_ptr, idle_at, issue_c, done_c, m_id;
        bit m_st;
        logic [AW-1:0] m_addr;
        logic [DW-1:0] m_wd, exp_d;
        logic [N-1:0] exp_ready, exp_done;
        bit pend [N];
        bit st [N];
        logic [AW-1:0] a [N];
        logic [DW-1:0] d [N];
        m_ptr = 0; idle_at = 0; issue_c = -1; done_c = -1; m_id = 0;
        m_st = 1'b0; m_addr = '0; m_wd = '0;
        for (int i = 0; i < N; i++) begin pend[i] = 1'b0; st[i] = 1'b0; a[i] = '0; d[i] = '0; end
        exp_q.delete();
        do_reset();
        for (int k = 0; k < 1500; k++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (pend[i] && $urandom_range(0, 15) == 0) pend[i] = 1'b0;
                else if (!pend[i] && $urandom_range(0, 3) == 0) begin
                    pend[i] = 1'b1;
                    st[i]   = 1'($urandom_range(0, 1));
                    a[i]    = AW'($urandom);
                    d[i]    = DW'($urandom);
                end
                req_valid[i]          = pend[i];
                req_is_store[i]       = st[i];
                req_addr[i*AW +: AW]  = a[i];
                req_wdata[i*DW +: DW] = d[i];
            end
            #1;
            exp_ready = '0;
            if (k >= idle_at) begin
                for (int j = 0; j < N; j++) begin
                    if (pend[(m_ptr + j) % N] && exp_ready == '0) exp_ready[(m_ptr + j) % N] = 1'b1;
                end
            end
            exp_done = (k == done_c) ? 4'(1 << m_id) : 4'b0000;
            n_tests++;
            if (req_ready !== exp_ready) begin n_fail++; $display("FAIL rnd_ready k=%0d got %b want %b", k, req_ready, exp_ready); end
            n_tests++;
            if (busy !== (k < idle_at)) begin n_fail++; $display("FAIL rnd_busy k=%0d got %b want %b", k, busy, k < idle_at); end
            n_tests++;
            if (mem_read_en !== (k == issue_c && !m_st) || mem_write_en !== (k == issue_c && m_st)) begin
                n_fail++; $display("FAIL rnd_enables k=%0d got re=%b we=%b want re=%b we=%b", k, mem_read_en,
                                   mem_write_en, k == issue_c && !m_st, k == issue_c && m_st);
            end
            if (k == issue_c) begin
                n_tests++;
                if (mem_addr !== m_addr || (m_st && mem_wdata !== m_wd)) begin
                    n_fail++; $display("FAIL rnd_payload k=%0d got a=%h wd=%h want a=%h wd=%h", k, mem_addr, mem_wdata, m_addr, m_wd);
                end
            end
            n_tests++;
            if (done !== exp_done) begin n_fail++; $display("FAIL rnd_done k=%0d got %b want %b", k, done, exp_done); end
            if (k == done_c && exp_q.size() > 0) begin
                exp_d = exp_q.pop_front();
                n_tests++;
                if (resp_rdata !== exp_d) begin n_fail++; $display("FAIL rnd_rdata k=%0d got %h want %h", k, resp_rdata, exp_d); end
            end
            for (int w = 0; w < N; w++) begin
                if (exp_ready[w]) begin
                    m_id = w; m_st = st[w]; m_addr = a[w];
                    if (st[w]) m_wd = d[w];
                    exp_q.push_back(st[w] ? '0 : mem_img[a[w]]);
                    issue_c = k + 1;
                    done_c  = st[w] ? k + 2 : k + 2 + L;
                    idle_at = done_c + 1;
                    m_ptr   = (w + 1) % N;
                    pend[w] = 1'b0;
                end
            end
        end
        @(negedge clk); req_valid = '0;
        repeat (L + 3) @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        req_valid = '0; req_is_store = '0; req_addr = '0; req_wdata = '0;
        mem_rdata = '0;
        for (int i = 0; i < 256; i++) mem_img[i] = DW'($urandom);
        mem_img[8'h3C] = 16'hBEEF;
        for (int i = 0; i < 8; i++) begin rd_v[i] = 1'b0; rd_a[i] = '0; end
        test_reset();
        test_single_load();
        test_single_store();
        test_round_robin();
        test_wrap();
        test_withdraw();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
